// File: rtl/uart_rx_timing_gen.sv
// Oversampling edge/bit timing generator for the UART receiver with a
// configurable frame format (data width, optional parity, one or two stop bits).
module uart_rx_timing_gen #(
  parameter int DATA_WIDTH    = 8,
  parameter int PRESC_WIDTH   = 6,
  parameter int BIT_CNT_WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     enable,
  input  logic [PRESC_WIDTH-1:0]   prescale,
  input  logic                     par_en,
  input  logic                     stop2,
  output logic [PRESC_WIDTH-1:0]   edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0] bit_cnt,
  output logic                     sample_stb,
  output logic [1:0]               sample_idx,
  output logic                     bit_done,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     cfg_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [PRESC_WIDTH-1:0]   MIN_PRESC = PRESC_WIDTH'(4);
  localparam logic [BIT_CNT_WIDTH-1:0] BASE_FL   = BIT_CNT_WIDTH'(DATA_WIDTH + 2);

  state_e                   state_q, state_d;
  logic [PRESC_WIDTH-1:0]   edge_q, edge_d;
  logic [BIT_CNT_WIDTH-1:0] bit_q, bit_d;
  logic [PRESC_WIDTH-1:0]   pl_q, pl_d;
  logic [BIT_CNT_WIDTH-1:0] fl_q, fl_d;
  logic                     cfg_err_q, cfg_err_d;

  logic                     presc_legal;
  logic [BIT_CNT_WIDTH-1:0] fl_in;
  logic                     last_edge;
  logic                     last_bit;
  logic [PRESC_WIDTH-1:0]   mid;
  logic [PRESC_WIDTH-1:0]   mid_m1;
  logic [PRESC_WIDTH-1:0]   mid_p1;

  assign presc_legal = (prescale >= MIN_PRESC);
  assign fl_in       = BASE_FL + BIT_CNT_WIDTH'(par_en) + BIT_CNT_WIDTH'(stop2);
  assign last_edge   = (edge_q == (pl_q - PRESC_WIDTH'(1)));
  assign last_bit    = (bit_q == (fl_q - BIT_CNT_WIDTH'(1)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      pl_q      <= '0;
      fl_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      pl_q      <= pl_d;
      fl_q      <= fl_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Config is only sampled when entering RUN or at a frame wrap, so inputs
  // may change freely mid-frame without disturbing the current timing.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    bit_d     = bit_q;
    pl_d      = pl_q;
    fl_d      = fl_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (enable) begin
          if (presc_legal) begin
            state_d   = RUN;
            pl_d      = prescale;
            fl_d      = fl_in;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else begin
          cfg_err_d = 1'b0;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end else if (last_edge) begin
          edge_d = '0;
          if (last_bit) begin
            bit_d = '0;
            if (presc_legal) begin
              pl_d = prescale;
              fl_d = fl_in;
            end else begin
              state_d   = IDLE;
              cfg_err_d = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_CNT_WIDTH'(1);
          end
        end else begin
          edge_d = edge_q + PRESC_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign mid    = pl_q >> 1;
  assign mid_m1 = mid - PRESC_WIDTH'(1);
  assign mid_p1 = mid + PRESC_WIDTH'(1);

  // Three majority-vote sample points centred on the middle of each bit.
  always_comb begin
    sample_stb = 1'b0;
    sample_idx = 2'd0;
    if (busy) begin
      if (edge_q == mid_m1) begin
        sample_stb = 1'b1;
        sample_idx = 2'd0;
      end else if (edge_q == mid) begin
        sample_stb = 1'b1;
        sample_idx = 2'd1;
      end else if (edge_q == mid_p1) begin
        sample_stb = 1'b1;
        sample_idx = 2'd2;
      end
    end
  end

  assign busy       = (state_q == RUN);
  assign bit_done   = busy & last_edge;
  assign frame_done = bit_done & last_bit;
  assign edge_cnt   = edge_q;
  assign bit_cnt    = bit_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_timing_gen.sv
// Self-checking bench for uart_rx_timing_gen: a directed vector table for the
// short IDLE/RUN/config-error cases plus hand-written multi-frame sequences.
module tb_uart_rx_timing_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic [5:0] prescale;
  logic       par_en;
  logic       stop2;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sample_stb;
  logic [1:0] sample_idx;
  logic       bit_done;
  logic       frame_done;
  logic       busy;
  logic       cfg_err;

  int vectorsApplied = 0;
  int miscompares    = 0;
  int bdSeen         = 0;
  int fdSeen         = 0;

  typedef struct {
    logic        en;
    logic [5:0]  presc;
    logic        par;
    logic        stp;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[17];

  uart_rx_timing_gen #(
    .DATA_WIDTH(8),
    .PRESC_WIDTH(6),
    .BIT_CNT_WIDTH(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .enable(enable),
    .prescale(prescale),
    .par_en(par_en),
    .stop2(stop2),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .sample_stb(sample_stb),
    .sample_idx(sample_idx),
    .bit_done(bit_done),
    .frame_done(frame_done),
    .busy(busy),
    .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  // Packed order: busy, edge, bit, stb, idx, bit_done, frame_done, cfg_err.
  function automatic logic [16:0] pk(input logic b, input int e, input int bt,
                                     input logic s, input int ix, input logic bd,
                                     input logic fd, input logic ce);
    return {b, 6'(e), 4'(bt), s, 2'(ix), bd, fd, ce};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [5:0] p,
                               input logic par, input logic stp);
    enable   = en;
    prescale = p;
    par_en   = par;
    stop2    = stp;
    tick();
  endtask

  task automatic checkOutput(input string nm, input logic [16:0] exp);
    logic [16:0] act;
    act = {busy, edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, cfg_err};
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got busy=%0b edge=%0d bit=%0d stb=%0b idx=%0d bd=%0b fd=%0b cfg=%0b, expected busy=%0b edge=%0d bit=%0d stb=%0b idx=%0d bd=%0b fd=%0b cfg=%0b",
               nm, act[16], act[15:10], act[9:6], act[5], act[4:3], act[2], act[1], act[0],
               exp[16], exp[15:10], exp[9:6], exp[5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic checkCount(input string nm, input int got, input int want);
    vectorsApplied++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // Walks n RUN cycles from a frame start; expected values come from the
  // bit/edge enumeration of a frame of fl bits with p clocks per bit.
  task automatic runCycles(input string tag, input int p, input int fl, input int n,
                           input int changeAt, input logic [5:0] newPresc);
    for (int k = 0; k < n; k++) begin
      int   e;
      int   b;
      int   m;
      int   ix;
      logic s;
      logic bd;
      logic fd;
      e  = k % p;
      b  = (k / p) % fl;
      m  = p / 2;
      s  = (e == m - 1) || (e == m) || (e == m + 1);
      ix = (e == m) ? 1 : ((e == m + 1) ? 2 : 0);
      bd = (e == p - 1);
      fd = bd && (b == fl - 1);
      checkOutput($sformatf("%s[%0d]", tag, k), pk(1'b1, e, b, s, ix, bd, fd, 1'b0));
      if (bit_done) bdSeen++;
      if (frame_done) fdSeen++;
      if (k == changeAt) prescale = newPresc;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST      = 1'b1;
    enable   = 1'b0;
    prescale = 6'd8;
    par_en   = 1'b0;
    stop2    = 1'b0;
    #2;
    checkOutput("reset", pk(0, 0, 0, 0, 0, 0, 0, 0));
    #10;
    RST = 1'b0;

    vecs[0]  = '{1'b0, 6'd8, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1'b1, 6'd3, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[2]  = '{1'b1, 6'd3, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[3]  = '{1'b1, 6'd4, 1'b0, 1'b0, pk(1, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{1'b1, 6'd4, 1'b0, 1'b0, pk(1, 1, 0, 1, 0, 0, 0, 0)};
    vecs[5]  = '{1'b1, 6'd4, 1'b0, 1'b0, pk(1, 2, 0, 1, 1, 0, 0, 0)};
    vecs[6]  = '{1'b1, 6'd4, 1'b0, 1'b0, pk(1, 3, 0, 1, 2, 1, 0, 0)};
    vecs[7]  = '{1'b1, 6'd4, 1'b0, 1'b0, pk(1, 0, 1, 0, 0, 0, 0, 0)};
    vecs[8]  = '{1'b0, 6'd4, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{1'b0, 6'd3, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[10] = '{1'b1, 6'd3, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[11] = '{1'b1, 6'd5, 1'b0, 1'b0, pk(1, 0, 0, 0, 0, 0, 0, 0)};
    vecs[12] = '{1'b1, 6'd5, 1'b0, 1'b0, pk(1, 1, 0, 1, 0, 0, 0, 0)};
    vecs[13] = '{1'b1, 6'd5, 1'b0, 1'b0, pk(1, 2, 0, 1, 1, 0, 0, 0)};
    vecs[14] = '{1'b1, 6'd5, 1'b0, 1'b0, pk(1, 3, 0, 1, 2, 0, 0, 0)};
    vecs[15] = '{1'b1, 6'd5, 1'b0, 1'b0, pk(1, 4, 0, 0, 0, 1, 0, 0)};
    vecs[16] = '{1'b0, 6'd5, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0)};

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].en, vecs[i].presc, vecs[i].par, vecs[i].stp);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Three back-to-back 8N1 frames at P=8.
    bdSeen = 0;
    fdSeen = 0;
    applyStimulus(1'b1, 6'd8, 1'b0, 1'b0);
    runCycles("frames8N1", 8, 10, 240, -1, 6'd8);
    checkCount("bitDoneCount", bdSeen, 30);
    checkCount("frameDoneCount", fdSeen, 3);

    // Abort mid-bit, then restart from bit 0.
    fdSeen = 0;
    runCycles("preAbort", 8, 10, 34, -1, 6'd8);
    checkOutput("abortPoint", pk(1, 2, 4, 0, 0, 0, 0, 0));
    enable = 1'b0;
    tick();
    checkOutput("abortIdle", pk(0, 0, 0, 0, 0, 0, 0, 0));
    checkCount("abortNoFrameDone", fdSeen, 0);
    enable = 1'b1;
    tick();
    checkOutput("restart", pk(1, 0, 0, 0, 0, 0, 0, 0));

    // Enable drops on the very cycle frame_done is decoded.
    runCycles("preDrop", 8, 10, 79, -1, 6'd8);
    enable = 1'b0;
    checkOutput("fdWithDrop", pk(1, 7, 9, 0, 0, 1, 1, 0));
    tick();
    checkOutput("idleAfterDrop", pk(0, 0, 0, 0, 0, 0, 0, 0));

    // P=16 with parity and two stop bits; prescale change mid-frame waits for the wrap.
    applyStimulus(1'b1, 6'd16, 1'b1, 1'b1);
    runCycles("frameP16FL12", 16, 12, 192, 50, 6'd8);
    runCycles("frameP8FL12", 8, 12, 96, 10, 6'd2);
    checkOutput("illegalWrap", pk(0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus(1'b1, 6'd8, 1'b0, 1'b0);
    checkOutput("recoverRun", pk(1, 0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset between clock edges, mid-frame.
    runCycles("preReset", 8, 10, 20, -1, 6'd8);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checkOutput("asyncReset", pk(0, 0, 0, 0, 0, 0, 0, 0));
    enable = 1'b0;
    tick();
    checkOutput("holdReset", pk(0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    RST = 1'b0;
    tick();
    checkOutput("idleAfterReset", pk(0, 0, 0, 0, 0, 0, 0, 0));
    bdSeen = 0;
    fdSeen = 0;
    applyStimulus(1'b1, 6'd8, 1'b0, 1'b0);
    runCycles("frameAfterReset", 8, 10, 80, -1, 6'd8);
    checkCount("fdAfterReset", fdSeen, 1);
    enable = 1'b0;
    tick();
    checkOutput("finalIdle", pk(0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_timing_gen.md
Name: uart_rx_timing_gen

Overview:
- Parametrised bit-timing generator for the UART receiver. It is the successor to the fixed 8N1 edge/bit counter.
- Counts oversampling edges and frame bit positions for a configurable frame format (data width, optional parity, one or two stop bits).
- Emits three-point majority-sample strobes, per-bit and per-frame completion pulses, and a configuration error flag.
- Sits between the RX control FSM, which drives enable, and the data/parity/stop samplers, which consume the strobes.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
PRESC_WIDTH, 6, width of the prescale input and edge counter.
BIT_CNT_WIDTH, 4, width of the bit counter; must hold DATA_WIDTH+3.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous reset, active-high.
enable  input  1  run request from the RX FSM; low means abort/idle.
prescale  input  PRESC_WIDTH  oversampling ratio P (clocks per bit).
par_en  input  1  parity bit present in frame.
stop2  input  1  two stop bits when high, one when low.
edge_cnt  output  PRESC_WIDTH  edge index within the current bit, 0..P-1.
bit_cnt  output  BIT_CNT_WIDTH  bit index in the frame; 0 = start bit.
sample_stb  output  1  sample-point strobe.
sample_idx  output  2  which sample point: 0, 1 or 2.
bit_done  output  1  last edge of the current bit.
frame_done  output  1  last edge of the last bit of the frame.
busy  output  1  high while in RUN.
cfg_err  output  1  illegal prescale requested.

Behaviour:
- Reset (RST=1, asynchronous): state IDLE, edge_cnt=0, bit_cnt=0, latched config cleared, cfg_err=0. All strobes are 0.
- States: IDLE and RUN.
- Latched config:
  - Pl = prescale.
  - FL (frame length) = 1 + DATA_WIDTH + par_en + 1 + stop2.
  - Latched on every IDLE->RUN transition and on every frame wrap.
  - Input changes between latch points have no effect.
- IDLE:
  - enable=1 and prescale>=4: go to RUN next cycle with edge_cnt=0, bit_cnt=0.
  - enable=1 and prescale<4: stay IDLE; cfg_err=1 (registered) until enable falls or prescale becomes legal.
  - enable=0: cfg_err=0.
- RUN, enable=1:
  - edge_cnt increments each cycle.
  - At edge_cnt==Pl-1: edge_cnt wraps to 0 and bit_cnt increments.
  - At edge_cnt==Pl-1 with bit_cnt==FL-1: both counters go to 0, config is re-latched, and RUN continues (back-to-back frames, no idle cycle).
  - If prescale is illegal at the wrap: go to IDLE and set cfg_err.
- RUN, enable=0 (any cycle, including mid-bit): next cycle IDLE, counters 0. No frame_done pulse.
- Let M = floor(Pl/2).
  - sample_stb=1 when busy and edge_cnt is M-1, M or M+1.
  - sample_idx = 0, 1, 2 respectively; sample_idx=0 otherwise.
- bit_done = busy and edge_cnt==Pl-1.
- frame_done = bit_done and bit_cnt==FL-1.
- busy, sample_stb, sample_idx, bit_done and frame_done are decoded combinationally from registered state and counters. There are no glitch requirements beyond a single clock domain.
- Frame duration is exactly FL*Pl cycles from the first RUN cycle to the cycle after frame_done.
- Simultaneous enable fall and frame_done in the same cycle: frame_done still pulses (it is decoded from the counters); next state is IDLE.
- The edge counter never exceeds Pl-1. The bit counter never exceeds FL-1.
- Reset mid-frame: immediate return to reset values. No pulses are emitted after reset deasserts until enable is seen.

Test Plan:
- DATA_WIDTH=8, P=8, par_en=0, stop2=0, enable held high for 1 frame:
  - 10 bits, 80 RUN cycles.
  - sample_stb at edge_cnt 3, 4, 5 of every bit.
  - bit_done 10 times.
  - frame_done once, at bit_cnt=9, edge_cnt=7.
- P=16, par_en=1, stop2=1:
  - FL=12; frame_done after 192 cycles.
  - Sample strobes at edges 7, 8, 9.
  - prescale changed to 8 mid-frame is ignored until the wrap.
- enable kept high across 3 frames with P=8:
  - frame_done every 80 cycles.
  - bit_cnt wraps 9->0 with no gap cycle.
  - busy stays 1 throughout.
- enable dropped at bit_cnt=4, edge_cnt=2:
  - Next cycle busy=0 and counters 0.
  - No frame_done.
  - Re-raising enable restarts at bit 0, edge 0.
- prescale=3 with enable=1:
  - cfg_err=1 on the next cycle, busy stays 0.
  - Changing to prescale=4 clears cfg_err and starts RUN; sample_stb at edges 1, 2, 3.
- RST pulsed asynchronously mid-frame (between clock edges):
  - Outputs reach reset values before the next clock edge.
  - After release with enable=1, a full frame is timed correctly.
